// File: rtl/amm_cfg_pkg.sv
// amm_cfg_pkg: shared sequencer states and register map of the key-pattern/enable control block
package amm_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DIS,
        ST_WR_KEY,
        ST_WR_EN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    localparam int CTRL_ADDR     = 0;
    localparam int KEY_BASE_ADDR = 1;
    localparam int ENABLE_BIT    = 0;

endpackage

// File: rtl/amm_cfg_master_if.sv
// avalon_mm_if: Avalon-MM command/response bundle between the config master and the control register slave
interface avalon_mm_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] address;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, write, read, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, read, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/amm_wr_rd_port.sv
// amm_wr_rd_port: presents the sequencer's registered command on the bus and reports its acceptance/response.
// Read tracking and the read timeout exist only when AMM_CFG_READBACK_EN is defined.
module amm_wr_rd_port #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_DEPTH  = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    avalon_mm_if.master          bus,
    input  logic                 wr_i,
    input  logic                 rd_i,
    input  logic [REG_DEPTH-1:0] addr_i,
    input  logic [REG_WIDTH-1:0] wdata_i,
    output logic                 acc_o,
    output logic                 rvalid_o,
    output logic                 timeout_o,
    output logic [REG_WIDTH-1:0] rdata_o
);

    assign bus.address   = addr_i;
    assign bus.write     = wr_i;
    assign bus.read      = rd_i;
    assign bus.writedata = wdata_i;
    assign acc_o         = (wr_i | rd_i) & ~bus.waitrequest;
    assign rdata_o       = bus.readdata;

`ifdef AMM_CFG_READBACK_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;

    // Timeout fires on the last cycle a response may still arrive, so the error lands RD_TIMEOUT cycles after acceptance
    assign rvalid_o  = pend_q & bus.readdatavalid;
    assign timeout_o = pend_q & ~bus.readdatavalid & (cnt_q == CNT_W'(RD_TIMEOUT - 2));

    // Single outstanding read: opened on acceptance, closed by data or timeout
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else if (rd_i && acc_o) begin
            pend_q <= 1'b1;
            cnt_q  <= '0;
        end else if (pend_q && (bus.readdatavalid || timeout_o)) begin
            pend_q <= 1'b0;
        end else if (pend_q) begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_rd;

    assign rvalid_o  = 1'b0;
    assign timeout_o = 1'b0;
    assign unused_rd = ^{clk_i, srst_i, bus.readdatavalid, 1'(RD_TIMEOUT)};
`endif

endmodule

// File: rtl/amm_cfg_master.sv
// amm_cfg_master: programs the key-pattern/enable registers (disable, PAT_WIDTH key words, enable).
// Optional readback verification of every written register is enabled by AMM_CFG_READBACK_EN.
module amm_cfg_master
    import amm_cfg_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int REG_DEPTH  = 4,
    parameter int PAT_WIDTH  = REG_DEPTH - 1,
    parameter int PAT_SIZE   = PAT_WIDTH * REG_WIDTH,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                start_i,
    input  logic [0:PAT_SIZE-1] pattern_i,
    input  logic                enable_i,
    avalon_mm_if.master         amm_master_if,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);

    localparam int IDX_W = $clog2(REG_DEPTH) + 1;

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [REG_DEPTH-1:0]   addr_q;
    logic                   wr_q;
    logic [REG_WIDTH-1:0]   wdata_q;
    logic [0:PAT_SIZE-1]    pat_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   rd;
    logic                   acc;
    logic                   rvalid;
    logic                   timeout;
    logic [REG_WIDTH-1:0]   rdata;
    logic [IDX_W-1:0]       idx_nxt;
    logic [REG_WIDTH-1:0]   word_w [2**IDX_W];

    assign idx_nxt = idx_q + IDX_W'(1);

    // Register image indexed by address: 0 is the enable word, 1..PAT_WIDTH the key words (first key = leading pattern bits)
    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_word
        if (g == CTRL_ADDR) begin : g_ctrl
            assign word_w[g] = REG_WIDTH'(en_q) << ENABLE_BIT;
        end else if (g <= PAT_WIDTH) begin : g_key
            assign word_w[g] = pat_q[(g-1)*REG_WIDTH +: REG_WIDTH];
        end else begin : g_none
            assign word_w[g] = '0;
        end
    end

`ifdef AMM_CFG_READBACK_EN
    logic rd_q;
    assign rd = rd_q;
`else
    logic unused_rd;
    assign rd        = 1'b0;
    assign unused_rd = ^{rvalid, timeout, rdata};
`endif

    amm_wr_rd_port #(
        .REG_WIDTH (REG_WIDTH),
        .REG_DEPTH (REG_DEPTH),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) u_port (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .bus      (amm_master_if),
        .wr_i     (wr_q),
        .rd_i     (rd),
        .addr_i   (addr_q),
        .wdata_i  (wdata_q),
        .acc_o    (acc),
        .rvalid_o (rvalid),
        .timeout_o(timeout),
        .rdata_o  (rdata)
    );

    // Sequencer: each accepted command loads the next command into the bus registers at the same edge
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
`ifdef AMM_CFG_READBACK_EN
            rd_q    <= 1'b0;
`endif
            wdata_q <= '0;
            pat_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    pat_q   <= pattern_i;
                    en_q    <= enable_i;
                    busy_q  <= 1'b1;
                    wr_q    <= 1'b1;
                    addr_q  <= REG_DEPTH'(CTRL_ADDR);
                    wdata_q <= '0;
                    state_q <= ST_WR_DIS;
                end
                ST_WR_DIS: if (acc) begin
                    idx_q   <= IDX_W'(KEY_BASE_ADDR);
                    addr_q  <= REG_DEPTH'(KEY_BASE_ADDR);
                    wdata_q <= word_w[KEY_BASE_ADDR];
                    state_q <= ST_WR_KEY;
                end
                ST_WR_KEY: if (acc) begin
                    if (idx_q == IDX_W'(PAT_WIDTH)) begin
                        addr_q  <= REG_DEPTH'(CTRL_ADDR);
                        wdata_q <= word_w[CTRL_ADDR];
                        state_q <= ST_WR_EN;
                    end else begin
                        idx_q   <= idx_nxt;
                        addr_q  <= REG_DEPTH'(idx_nxt);
                        wdata_q <= word_w[idx_nxt];
                    end
                end
                ST_WR_EN: if (acc) begin
                    wr_q    <= 1'b0;
`ifdef AMM_CFG_READBACK_EN
                    idx_q   <= IDX_W'(CTRL_ADDR);
                    addr_q  <= REG_DEPTH'(CTRL_ADDR);
                    rd_q    <= 1'b1;
                    state_q <= ST_RD_REQ;
`else
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
`endif
                end
`ifdef AMM_CFG_READBACK_EN
                ST_RD_REQ: if (acc) begin
                    rd_q    <= 1'b0;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (timeout || (rvalid && rdata != word_w[idx_q])) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (rvalid && idx_q == IDX_W'(PAT_WIDTH)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (rvalid) begin
                        idx_q   <= idx_nxt;
                        addr_q  <= REG_DEPTH'(idx_nxt);
                        rd_q    <= 1'b1;
                        state_q <= ST_RD_REQ;
                    end
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = err_q;

endmodule

// File: tb/tb_amm_cfg_master.sv
// tb_amm_cfg_master: randomized bench for amm_cfg_master with a write-list/latency reference model
module tb_amm_cfg_master;

    localparam int RW = 32;
    localparam int RD = 4;
    localparam int PW = RD - 1;

    logic          clk = 0, srst = 1, start = 0, enable = 0;
    logic [PW*RW-1:0] pattern = '0;
    logic          busy, done, error;
    int cyc = 0, total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, s_cyc = 0, stall_cnt = 0;
    int stall_addr = -1, stall_left = 0, wait_pct = 0, corrupt_addr = -1, rd_acc_cyc = 0;
    bit withhold = 0, rd_acc_seen = 0, prev_stall = 0;
    logic [RD-1:0] prev_addr = '0, rd_addr = '0;
    logic [RW-1:0] prev_data = '0;
    logic [RW-1:0] mem [16];
    int            wa[$], ra[$];
    logic [RW-1:0] wd[$];

    avalon_mm_if #(.ADDR_W(RD), .DATA_W(RW)) bus();

    amm_cfg_master dut (
        .clk_i(clk), .srst_i(srst), .start_i(start), .pattern_i(pattern), .enable_i(enable),
        .amm_master_if(bus), .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and register-file slave state, sampled mid-cycle
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_wr", bus.write, 1);
            chk("hold_addr", bus.address, prev_addr);
            chk("hold_data", bus.writedata, prev_data);
        end
        prev_stall = bus.write && bus.waitrequest;
        prev_addr  = bus.address;
        prev_data  = bus.writedata;
        if (bus.write) chk("rw_excl", bus.read, 0);
        if (bus.write && bus.waitrequest) stall_cnt++;
        if (bus.write && !bus.waitrequest) begin
            wa.push_back(int'(bus.address));
            wd.push_back(bus.writedata);
            mem[bus.address] = bus.writedata;
        end
        if (bus.read && !bus.waitrequest) begin
            ra.push_back(int'(bus.address));
            rd_addr = bus.address;
            rd_acc_seen = 1;
            rd_acc_cyc = cyc;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
    end

    // Slave responses: one-cycle read latency, scripted or random waitrequest
    always @(posedge clk) begin
        #1;
        bus.readdatavalid = 0;
        if (rd_acc_seen) begin
            rd_acc_seen = 0;
            if (!withhold) begin
                bus.readdatavalid = 1;
                bus.readdata = (int'(rd_addr) == corrupt_addr) ? 32'hDEADBEEF : mem[rd_addr];
            end
        end
        if (bus.write && int'(bus.address) == stall_addr && stall_left > 0) begin
            bus.waitrequest = 1;
            stall_left--;
        end else begin
            bus.waitrequest = ($urandom_range(0, 99) < wait_pct);
        end
    end

    task automatic start_cfg(input logic [PW*RW-1:0] pat, input logic en);
        wa.delete(); wd.delete(); ra.delete();
        stall_cnt = 0;
        @(posedge clk); #1;
        pattern = pat; enable = en; start = 1; s_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        chk("busy_on", busy, 1);
    endtask

    task automatic wait_end(output int lat);
        int n, d0, e0;
        n = 0; d0 = done_cnt; e0 = err_cnt;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("no_hang", n < 300, 1);
        lat = (done_cnt != d0) ? done_cyc - s_cyc : err_cyc - s_cyc;
        repeat (4) @(posedge clk);
        #1 chk("busy_off", busy, 0);
    endtask

    // Reference: disable, key words in order (first key = most significant pattern word), then enable
    task automatic chk_writes(input logic [PW*RW-1:0] pat, input logic en);
        int ea[$];
        logic [RW-1:0] ed[$];
        ea.push_back(0); ed.push_back(0);
        for (int i = 1; i <= PW; i++) begin
            ea.push_back(i);
            ed.push_back(RW'(pat >> (RW * (PW - i))));
        end
        ea.push_back(0); ed.push_back({31'b0, en});
        chk("wr_cnt", wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), wa[i], ea[i]);
            chk($sformatf("wr_data%0d", i), wd[i], ed[i]);
        end
    endtask

    initial begin
        int lat, n, d0, e0;
        logic [PW*RW-1:0] p;
        logic e;
        bus.waitrequest = 0; bus.readdata = 0; bus.readdatavalid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", bus.write, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_addr", bus.address, 0);
        chk("rst_wdata", bus.writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        srst = 0;

        p = 96'h11111111_22222222_33333333;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(p, 1); wait_end(lat); chk_writes(p, 1);
`ifndef AMM_CFG_READBACK_EN
        chk("lat_basic", lat, 6);
`endif
        chk("done_basic", done_cnt - d0, 1);
        chk("err_basic", err_cnt - e0, 0);

        stall_addr = 2; stall_left = 3;
        start_cfg(p, 0); wait_end(lat); chk_writes(p, 0);
`ifndef AMM_CFG_READBACK_EN
        chk("lat_stall", lat, 9);
`endif
        chk("stalls", stall_cnt, 3);
        stall_addr = -1;

        p = {$urandom(), $urandom(), $urandom()};
        d0 = done_cnt;
        start_cfg(p, 1);
        @(posedge clk); #1;
        pattern = ~p; enable = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_end(lat); chk_writes(p, 1);
        chk("one_done", done_cnt - d0, 1);

        d0 = done_cnt;
        start_cfg(p, 1);
        n = 0;
        while (!(bus.write && bus.address == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_key2", n < 50, 1);
        srst = 1;
        @(posedge clk); #1;
        chk("abort_write", bus.write, 0);
        chk("abort_busy", busy, 0);
        srst = 0;
        repeat (3) @(posedge clk);
        chk("abort_nodone", done_cnt - d0, 0);
        p = {$urandom(), $urandom(), $urandom()};
        start_cfg(p, 0); wait_end(lat); chk_writes(p, 0);
`ifndef AMM_CFG_READBACK_EN
        chk("lat_restart", lat, 6);
`endif

        for (int t = 0; t < 8; t++) begin
            wait_pct = $urandom_range(0, 60);
            p = {$urandom(), $urandom(), $urandom()};
            e = 1'($urandom_range(0, 1));
            d0 = done_cnt; e0 = err_cnt;
            start_cfg(p, e); wait_end(lat); chk_writes(p, e);
`ifndef AMM_CFG_READBACK_EN
            chk("lat_rand", lat, 6 + stall_cnt);
`endif
            chk("done_rand", done_cnt - d0, 1);
            chk("err_rand", err_cnt - e0, 0);
        end
        wait_pct = 0;

`ifdef AMM_CFG_READBACK_EN
        p = 96'h11111111_22222222_33333333;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(p, 1); wait_end(lat);
        chk("rb_nreads", ra.size(), 4);
        for (int i = 0; i < 4 && i < ra.size(); i++) chk($sformatf("rb_addr%0d", i), ra[i], i);
        chk("rb_done", done_cnt - d0, 1);
        chk("rb_err", err_cnt - e0, 0);

        corrupt_addr = 2;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(p, 1); wait_end(lat);
        chk("bad_nreads", ra.size(), 3);
        chk("bad_err", err_cnt - e0, 1);
        chk("bad_nodone", done_cnt - d0, 0);
        corrupt_addr = -1;

        withhold = 1;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(p, 1); wait_end(lat);
        chk("tmo_nreads", ra.size(), 1);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_lat", err_cyc - rd_acc_cyc, 16);
        chk("tmo_nodone", done_cnt - d0, 0);
        withhold = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
